// File: rtl/key_command_conditioner_pkg.sv
// key_command_conditioner_pkg: shared types and default timing for the key command conditioner.
//   rpt_state_t : auto-repeat FSM states
//   cmd_t       : one-deep pending move command encoding
//   DEF_*       : default timing constants (50 MHz board clock)
package key_command_conditioner_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT, ST_BLOCKED} rpt_state_t;

   typedef enum logic [1:0] {CMD_NONE, CMD_LEFT, CMD_RIGHT} cmd_t;

   localparam int DEF_DEBOUNCE_CYCLES = 250000;
   localparam int DEF_REPEAT_DELAY    = 15000000;
   localparam int DEF_REPEAT_PERIOD   = 5000000;
   localparam int DEF_CNT_W           = 24;

   function automatic cmd_t dir_cmd(input logic is_left);
      return is_left ? CMD_LEFT : CMD_RIGHT;
   endfunction

endpackage

// File: rtl/key_command_conditioner_if.sv
// key_command_conditioner_if: command bus between the key conditioner and the rocket block.
//   ready    : consumer can take a move command this cycle (rocket drawEn low)
//   left     : pending left-move command (valid level)
//   right    : pending right-move command (valid level)
//   start    : debounced start key level, 1 = pressed
//   overflow : sticky, a move event was dropped
interface key_command_conditioner_if;
   logic ready;
   logic left;
   logic right;
   logic start;
   logic overflow;
   modport master (input ready, output left, output right, output start, output overflow);
   modport slave (output ready, input left, input right, input start, input overflow);
endinterface

// File: rtl/key_command_conditioner_debouncer.sv
// key_debouncer: synchronises and debounces one active-low raw key.
//   clk, reset : system clock, synchronous active-high reset
//   key_n      : raw asynchronous key, active-low
//   pressed    : debounced key state, 1 = pressed
//   press      : one-cycle pulse on a debounced released->pressed transition
module key_debouncer
   import key_command_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic pressed,
   output logic press
);

   logic s1, s2;
   logic [CNT_W-1:0] cnt;
   logic differ;

   // s2 is still active-low here; invert before comparing with the stable state
   assign differ = (~s2) != pressed;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1      <= 1'b1;
         s2      <= 1'b1;
         cnt     <= '0;
         pressed <= 1'b0;
         press   <= 1'b0;
      end else begin
         s1    <= key_n;
         s2    <= s1;
         press <= 1'b0;
         if (!differ)
            cnt <= '0;
         else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt     <= '0;
            pressed <= ~pressed;
            press   <= ~pressed;
         end else
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/key_command_conditioner.sv
// key_command_conditioner: turns raw DE1 push-buttons into clean rocket commands.
//   clk, reset  : system clock, synchronous active-high reset
//   key_left_n  : raw left key, active-low, asynchronous
//   key_right_n : raw right key, active-low, asynchronous
//   key_start_n : raw start key, active-low, asynchronous
//   cmd         : command bus (ready in; left, right, start, overflow out)
module key_command_conditioner
   import key_command_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic key_left_n,
   input  logic key_right_n,
   input  logic key_start_n,
   key_command_conditioner_if.master cmd
);

   logic sl, sr, ss;
   logic pl, pr, start_press_unused;
   rpt_state_t state;
   logic [CNT_W-1:0] rcnt;
   logic dir_left;
   logic ev, ev_left;
   cmd_t pending;
   logic start_q, ovf;
   logic held;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_left (
      .clk(clk), .reset(reset), .key_n(key_left_n), .pressed(sl), .press(pl));
   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_right (
      .clk(clk), .reset(reset), .key_n(key_right_n), .pressed(sr), .press(pr));
   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start (
      .clk(clk), .reset(reset), .key_n(key_start_n), .pressed(ss), .press(start_press_unused));

   assign held         = dir_left ? sl : sr;
   assign cmd.left     = pending == CMD_LEFT;
   assign cmd.right    = pending == CMD_RIGHT;
   assign cmd.start    = start_q;
   assign cmd.overflow = ovf;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         rcnt     <= '0;
         dir_left <= 1'b0;
         ev       <= 1'b0;
         ev_left  <= 1'b0;
         pending  <= CMD_NONE;
         start_q  <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         start_q <= ss;
         ev      <= 1'b0;
         // Both keys down blocks repeating; a simultaneous press from IDLE still yields one left event
         if (sl && sr) begin
            state <= ST_BLOCKED;
            rcnt  <= '0;
            if (state == ST_IDLE && pl && pr) begin
               ev      <= 1'b1;
               ev_left <= 1'b1;
            end
         end else begin
            case (state)
               ST_IDLE:
                  if (pl || pr) begin
                     ev       <= 1'b1;
                     ev_left  <= pl;
                     dir_left <= pl;
                     state    <= ST_DELAY;
                     rcnt     <= '0;
                  end
               ST_DELAY:
                  if (!held)
                     state <= ST_IDLE;
                  else if (rcnt == CNT_W'(REPEAT_DELAY - 1)) begin
                     ev      <= 1'b1;
                     ev_left <= dir_left;
                     state   <= ST_REPEAT;
                     rcnt    <= '0;
                  end else
                     rcnt <= rcnt + 1'b1;
               ST_REPEAT:
                  if (!held)
                     state <= ST_IDLE;
                  else if (rcnt == CNT_W'(REPEAT_PERIOD - 1)) begin
                     ev      <= 1'b1;
                     ev_left <= dir_left;
                     rcnt    <= '0;
                  end else
                     rcnt <= rcnt + 1'b1;
               ST_BLOCKED:
                  if (!sl && !sr)
                     state <= ST_IDLE;
               default:
                  state <= ST_IDLE;
            endcase
         end
         // A consume frees the slot in the same cycle, so a coincident event replaces rather than drops
         if (ev && (pending == CMD_NONE || cmd.ready))
            pending <= dir_cmd(ev_left);
         else if (cmd.ready)
            pending <= CMD_NONE;
         if (ev && pending != CMD_NONE && !cmd.ready)
            ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_key_command_conditioner.sv
// tb_key_command_conditioner: scoreboard bench for key_command_conditioner against a timing-rule reference model.
module tb_key_command_conditioner;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic key_left_n = 1'b1;
   logic key_right_n = 1'b1;
   logic key_start_n = 1'b1;

   key_command_conditioner_if bus();

   key_command_conditioner #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .key_left_n(key_left_n), .key_right_n(key_right_n),
      .key_start_n(key_start_n), .cmd(bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n_edge = 0;
   bit done = 0;

   // Reference model state: raw sample history per key (index 0 = newest edge)
   bit hist [3][DB+2];
   bit m_st [3];
   bit m_pu [3];
   int m_held, m_next, m_pend;
   bit m_blk, m_fire, m_fleft, m_ovf, m_start;

   logic [3:0] st_q [$];
   int cmd_q [$];

   // One clock edge of the model. Keys: 0 left, 1 right, 2 start. m_pend: 0 none, 1 left, 2 right.
   task automatic model_step(bit rst, bit [2:0] prs, bit rdy);
      bit f, fl, tog;
      n_edge++;
      if (rst) begin
         foreach (hist[k, i]) hist[k][i] = 0;
         for (int k = 0; k < 3; k++) begin
            m_st[k] = 0;
            m_pu[k] = 0;
         end
         m_held = 0; m_blk = 0; m_fire = 0; m_fleft = 0; m_pend = 0; m_ovf = 0; m_start = 0;
      end else begin
         if (rdy) m_pend = 0;
         if (m_fire) begin
            if (m_pend == 0) m_pend = m_fleft ? 1 : 2;
            else m_ovf = 1;
         end
         f = 0; fl = 0;
         if (m_st[0] && m_st[1]) begin
            if (!m_blk && m_held == 0 && m_pu[0] && m_pu[1]) begin f = 1; fl = 1; end
            m_blk = 1;
            m_held = 0;
         end else if (m_blk) begin
            if (!m_st[0] && !m_st[1]) m_blk = 0;
         end else if (m_held == 0) begin
            if (m_pu[0] || m_pu[1]) begin
               f = 1; fl = m_pu[0];
               m_held = fl ? 1 : 2;
               m_next = n_edge + RD;
            end
         end else if (!m_st[m_held-1]) begin
            m_held = 0;
         end else if (n_edge == m_next) begin
            f = 1; fl = (m_held == 1);
            m_next = n_edge + RP;
         end
         m_fire = f;
         m_fleft = fl;
         m_start = m_st[2];
         for (int k = 0; k < 3; k++) begin
            for (int i = DB + 1; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = prs[k];
            // accept a change once DB consecutive synchronised samples disagree with the stable state
            tog = 1;
            for (int i = 2; i < DB + 2; i++) if (hist[k][i] == m_st[k]) tog = 0;
            m_pu[k] = tog && !m_st[k];
            if (tog) m_st[k] = !m_st[k];
         end
      end
      st_q.push_back({m_pend == 1, m_pend == 2, m_start, m_ovf});
   endtask

   task automatic drive(bit l, bit r, bit s, bit rdy, bit rst);
      @(negedge clk);
      key_left_n = !l;
      key_right_n = !r;
      key_start_n = !s;
      bus.ready = rdy;
      reset = rst;
      if (!rst && rdy && m_pend != 0) cmd_q.push_back(m_pend);
      model_step(rst, {s, r, l}, rdy);
   endtask

   task automatic hold(int cyc, bit l, bit r, bit s, bit rdy);
      repeat (cyc) drive(l, r, s, rdy, 0);
   endtask

   task automatic rand_phase(int cyc, int glitch_pct, int rdy_pct, int rst_pm, bit tie);
      bit kp [3];
      int dur [3];
      for (int k = 0; k < 3; k++) begin
         kp[k] = 0;
         dur[k] = int'($urandom_range(1, 20));
      end
      repeat (cyc) begin
         for (int k = 0; k < 3; k++) begin
            if (dur[k] == 0) begin
               kp[k] = !kp[k];
               dur[k] = ($urandom_range(99) < glitch_pct) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 70));
            end else
               dur[k]--;
         end
         drive(kp[0], tie ? kp[0] : kp[1], kp[2], $urandom_range(99) < rdy_pct, $urandom_range(999) < rst_pm);
      end
   endtask

   // Stimulus
   initial begin
      bus.ready = 1'b0;
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      hold(5, 0, 0, 0, 1);
      hold(44, 1, 0, 0, 1);
      hold(20, 0, 0, 0, 1);
      repeat (8) begin
         hold(3, 0, 1, 0, 1);
         hold(3, 0, 0, 0, 1);
      end
      hold(10, 0, 0, 0, 1);
      hold(40, 1, 0, 0, 0);
      hold(10, 1, 0, 0, 1);
      hold(20, 0, 0, 0, 1);
      hold(40, 1, 1, 0, 1);
      hold(20, 0, 0, 0, 1);
      hold(15, 0, 1, 0, 1);
      hold(15, 0, 0, 0, 1);
      hold(10, 0, 0, 1, 1);
      hold(20, 0, 0, 0, 1);
      hold(15, 1, 0, 0, 1);
      drive(1, 0, 0, 1, 1);
      hold(20, 1, 0, 0, 1);
      hold(20, 0, 0, 0, 1);
      rand_phase(1500, 10, 70, 0, 0);
      rand_phase(1500, 30, 20, 2, 0);
      rand_phase(1500, 5, 50, 1, 1);
      hold(30, 0, 0, 0, 1);
      hold(3, 0, 0, 0, 0);
      @(negedge clk);
      done = 1;
   end

   // Monitor: per-edge output check, then handshake check once ready for the coming edge is driven
   initial begin
      logic [3:0] exp_v, got_v;
      int exp_c, got_c;
      forever begin
         @(posedge clk);
         #1;
         if (done) break;
         if (st_q.size() > 0) begin
            exp_v = st_q.pop_front();
            got_v = {bus.left, bus.right, bus.start, bus.overflow};
            checks++;
            if (got_v !== exp_v) begin
               errors++;
               if (errors < 30)
                  $display("FAIL outputs edge %0d: {left,right,start,overflow} got %b, required %b", n_edge, got_v, exp_v);
            end
         end
         @(negedge clk);
         #1;
         if (!reset && bus.ready && (bus.left || bus.right)) begin
            got_c = bus.left ? 1 : 2;
            checks++;
            if (cmd_q.size() == 0) begin
               errors++;
               if (errors < 30) $display("FAIL command: got dir %0d, required no command", got_c);
            end else begin
               exp_c = cmd_q.pop_front();
               if (got_c != exp_c) begin
                  errors++;
                  if (errors < 30) $display("FAIL command: got dir %0d, required dir %0d", got_c, exp_c);
               end
            end
         end
      end
      checks++;
      if (cmd_q.size() != 0) begin
         errors++;
         $display("FAIL leftover commands: got %0d unconsumed, required 0", cmd_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
